// File: rtl/line_memory_if.sv
// Line fill/write-back port between the data cache (master) and line_memory (slave).
interface line_memory_if #(
  parameter int LINE_BITS = 128
);
  logic                 in_mem_read_en;
  logic                 in_mem_write_en;
  logic [31:0]          in_mem_addr;
  logic [LINE_BITS-1:0] in_mem_write_data;
  logic [LINE_BITS-1:0] out_mem_read_data;
  logic                 out_mem_ready;
  logic                 out_busy;
  logic                 out_err;

  modport master (
    output in_mem_read_en, in_mem_write_en, in_mem_addr, in_mem_write_data,
    input  out_mem_read_data, out_mem_ready, out_busy, out_err
  );

  modport slave (
    input  in_mem_read_en, in_mem_write_en, in_mem_addr, in_mem_write_data,
    output out_mem_read_data, out_mem_ready, out_busy, out_err
  );
endinterface

// File: rtl/line_memory.sv
// Fixed-latency whole-line backing memory for the cache miss FSM.
// Optional address range checking is enabled by defining LINE_MEMORY_BOUNDS_CHECK_EN.
module line_memory #(
  parameter int LINE_BITS   = 128,
  parameter int DEPTH_LINES = 256,
  parameter int LATENCY     = 10
) (
  input  logic          clk,
  input  logic          reset,
  line_memory_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH_LINES);
  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic                 wr;
    logic                 oob;
    logic [IDX_W-1:0]     idx;
    logic [LINE_BITS-1:0] data;
  } req_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  req_t                 req;
  logic [LINE_BITS-1:0] mem [DEPTH_LINES];
  logic [LINE_BITS-1:0] rd_q;
  logic                 accept, fire, req_oob;
  logic                 unused_addr;

  assign accept = (state == IDLE) && (bus.in_mem_write_en || bus.in_mem_read_en);
  assign fire   = (state == BUSY) && (cnt == '0);

`ifdef LINE_MEMORY_BOUNDS_CHECK_EN
  logic err_q;
  assign req_oob     = bus.in_mem_addr[31:4] >= 28'(DEPTH_LINES);
  assign unused_addr = ^bus.in_mem_addr[3:0];
  assign bus.out_err = err_q;

  always_ff @(posedge clk) begin
    if (reset)       err_q <= 1'b0;
    else if (accept) err_q <= err_q | req_oob;
  end
`else
  // Upper address bits drop out, so the line index wraps modulo the depth.
  assign req_oob     = 1'b0;
  assign unused_addr = ^{bus.in_mem_addr[31:4+IDX_W], bus.in_mem_addr[3:0]};
  assign bus.out_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (fire)   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ready occupies exactly the DONE cycle, busy exactly the BUSY cycles.
  always_comb begin
    bus.out_mem_ready     = (state == DONE);
    bus.out_busy          = (state == BUSY);
    bus.out_mem_read_data = rd_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      req  <= '0;
      rd_q <= '0;
    end else begin
      if (accept) begin
        cnt      <= CNT_W'(LATENCY - 1);
        req.wr   <= bus.in_mem_write_en;
        req.oob  <= req_oob;
        req.idx  <= bus.in_mem_addr[4 +: IDX_W];
        req.data <= bus.in_mem_write_data;
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (fire && !req.wr) rd_q <= req.oob ? '0 : mem[req.idx];
    end
  end

  // Array holds its contents through reset; reset on the commit edge aborts the write.
  always_ff @(posedge clk) begin
    if (!reset && fire && req.wr && !req.oob) mem[req.idx] <= req.data;
  end
endmodule

// File: tb/tb_line_memory.sv
// Randomised bench for line_memory against a timeline/array model, plus directed literal checks.
module tb_line_memory;
  localparam int L     = 10;
  localparam int DEPTH = 256;
  localparam logic [127:0] D0 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] D1 = 128'hA5A5A5A5_11112222_33334444_5A5A5A5A;
  localparam logic [127:0] D2 = 128'hDEADBEEF_CAFEF00D_01020304_05060708;
  localparam logic [127:0] D3 = 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000;
  localparam logic [127:0] D4 = 128'h44444444_44444444_44444444_44444444;
  localparam logic [127:0] D5 = 128'h55555555_55555555_55555555_55555555;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  bit   chk_en = 1'b0;

  line_memory_if #(.LINE_BITS(128)) bus ();

  line_memory #(.LINE_BITS(128), .DEPTH_LINES(DEPTH), .LATENCY(L)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: an access is a timeline of L busy cycles then one ready cycle,
  // then one dead cycle before a new request can be taken.
  logic [127:0] mm [DEPTH];
  bit           m_active = 1'b0;
  int           m_since  = 0;
  bit           m_wr, m_oob;
  int           m_idx;
  logic [127:0] m_data;
  logic [127:0] exp_rd  = '0;
  bit           exp_err = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_active = 1'b0;
      exp_rd   = '0;
      exp_err  = 1'b0;
    end else if (m_active) begin
      m_since++;
      if (m_since == L) begin
        if (m_wr) begin
          if (!m_oob) mm[m_idx] = m_data;
        end else begin
          exp_rd = m_oob ? 128'b0 : mm[m_idx];
        end
      end else if (m_since == L + 1) begin
        m_active = 1'b0;
      end
    end else if (bus.in_mem_write_en || bus.in_mem_read_en) begin
      longint line;
      line     = longint'(bus.in_mem_addr) / 16;
      m_active = 1'b1;
      m_since  = 0;
      m_wr     = bus.in_mem_write_en;
      m_data   = bus.in_mem_write_data;
      m_idx    = int'(line % DEPTH);
`ifdef LINE_MEMORY_BOUNDS_CHECK_EN
      m_oob    = line >= DEPTH;
`else
      m_oob    = 1'b0;
`endif
      if (m_oob) exp_err = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit eb, er;
      eb = m_active && (m_since < L);
      er = m_active && (m_since == L);
      vectors++;
      if (bus.out_busy !== eb) begin
        miscompares++;
        $display("FAIL busy @%0t: got %b want %b", $time, bus.out_busy, eb);
      end
      if (bus.out_mem_ready !== er) begin
        miscompares++;
        $display("FAIL ready @%0t: got %b want %b", $time, bus.out_mem_ready, er);
      end
      if (bus.out_mem_read_data !== exp_rd) begin
        miscompares++;
        $display("FAIL rdata @%0t: got %h want %h", $time, bus.out_mem_read_data, exp_rd);
      end
      if (bus.out_err !== exp_err) begin
        miscompares++;
        $display("FAIL err @%0t: got %b want %b", $time, bus.out_err, exp_err);
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit we, input bit re, input logic [31:0] a, input logic [127:0] d);
    bus.in_mem_write_en   = we;
    bus.in_mem_read_en    = re;
    bus.in_mem_addr       = a;
    bus.in_mem_write_data = d;
  endtask

  // Runs one access from a negedge; hold keeps the enables up until ready is seen.
  task automatic access(input bit we, input bit re, input logic [31:0] a, input logic [127:0] d,
                        input bit hold, output int rdy_off, output int busy_n, output int pulses);
    rdy_off = -1;
    busy_n  = 0;
    pulses  = 0;
    drive(we, re, a, d);
    for (int k = 1; k <= L + 6; k++) begin
      @(negedge clk);
      if (!hold && k == 1) drive(1'b0, 1'b0, a, d);
      if (bus.out_busy === 1'b1) busy_n++;
      if (bus.out_mem_ready === 1'b1) begin
        pulses++;
        if (rdy_off < 0) rdy_off = k - 1;
        if (hold) drive(1'b0, 1'b0, a, d);
      end
    end
  endtask

  initial begin
    int off, bn, np;
    drive(1'b0, 1'b0, 32'h0, '0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    chk("reset_ready", 128'(bus.out_mem_ready), 128'd0);
    chk("reset_busy",  128'(bus.out_busy), 128'd0);
    chk("reset_rdata", bus.out_mem_read_data, 128'd0);
    chk("reset_err",   128'(bus.out_err), 128'd0);

    access(1'b1, 1'b0, 32'h40, D0, 1'b0, off, bn, np);
    chk("wr40_ready_offset", 128'(off), 128'd10);
    chk("wr40_busy_cycles",  128'(bn), 128'd10);
    chk("wr40_pulses",       128'(np), 128'd1);
    chk("wr40_rdata_kept",   bus.out_mem_read_data, 128'd0);

    access(1'b0, 1'b1, 32'h4C, '0, 1'b1, off, bn, np);
    chk("rd40_ready_offset", 128'(off), 128'd10);
    chk("rd40_held_pulses",  128'(np), 128'd1);
    chk("rd40_data",         bus.out_mem_read_data, D0);

    access(1'b1, 1'b1, 32'h80, D1, 1'b0, off, bn, np);
    chk("both_pulses",       128'(np), 128'd1);
    chk("both_rdata_kept",   bus.out_mem_read_data, D0);
    access(1'b0, 1'b1, 32'h80, '0, 1'b0, off, bn, np);
    chk("rd80_data",         bus.out_mem_read_data, D1);

    access(1'b1, 1'b0, 32'h100, D2, 1'b0, off, bn, np);
    drive(1'b1, 1'b0, 32'h100, D3);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h100, D3);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 128'(bus.out_busy), 128'd0);
    np = 0;
    repeat (L + 4) begin
      @(negedge clk);
      if (bus.out_mem_ready === 1'b1) np++;
    end
    chk("abort_pulses", 128'(np), 128'd0);
    access(1'b0, 1'b1, 32'h100, '0, 1'b0, off, bn, np);
    chk("rd100_prior", bus.out_mem_read_data, D2);

    access(1'b1, 1'b0, 32'h0, D5, 1'b0, off, bn, np);
    access(1'b1, 1'b0, 32'h1000, D4, 1'b0, off, bn, np);
    chk("oob_wr_pulses", 128'(np), 128'd1);
    access(1'b0, 1'b1, 32'h0, '0, 1'b0, off, bn, np);
`ifdef LINE_MEMORY_BOUNDS_CHECK_EN
    chk("oob_err",      128'(bus.out_err), 128'd1);
    chk("line0_intact", bus.out_mem_read_data, D5);
    access(1'b0, 1'b1, 32'h1000, '0, 1'b0, off, bn, np);
    chk("oob_rd_zero",  bus.out_mem_read_data, 128'd0);
`else
    chk("wrap_err",     128'(bus.out_err), 128'd0);
    chk("wrap_line0",   bus.out_mem_read_data, D4);
`endif

    for (int i = 0; i < 8; i++)
      access(1'b1, 1'b0, 32'(i * 16), {$urandom, $urandom, $urandom, $urandom}, 1'b0, off, bn, np);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      int op;
      a  = {$urandom_range(0, 3) == 0 ? 20'($urandom_range(1, 3)) : 20'h0, 12'h0};
      a |= 32'($urandom_range(0, 7) * 16 + $urandom_range(0, 15));
      op = $urandom_range(0, 2);
      drive(op != 1, op != 0, a, {$urandom, $urandom, $urandom, $urandom});
      repeat ($urandom_range(1, L + 4)) @(negedge clk);
      drive(1'b0, 1'b0, a, '0);
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
      repeat ($urandom_range(0, L + 3)) @(negedge clk);
    end

    repeat (L + 3) @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
